// File: rtl/ternary_seq_ctrl_if.sv
// Command, abort/stall and unit-drive signals of the ternary matmul phase sequencer.
// The host side uses master; the sequencer itself uses slave.
interface ternary_seq_ctrl_if #(
  parameter int MAX_OUT_LEN = 7,
  parameter int LEN_W       = 8,
  parameter int RW          = $clog2(MAX_OUT_LEN)
);
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_ready;
  logic             abort;
  logic             hold;
  logic             load_en;
  logic [RW:0]      load_idx;
  logic             mult_en;
  logic [RW-1:0]    mult_row;
  logic             vec_done;
  logic             weights_valid;
  logic             busy;
  logic             err;

  modport master (
    output cmd_valid, cmd_op, cmd_len, abort, hold,
    input  cmd_ready, load_en, load_idx, mult_en, mult_row, vec_done,
           weights_valid, busy, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, abort, hold,
    output cmd_ready, load_en, load_idx, mult_en, mult_row, vec_done,
           weights_valid, busy, err
  );
endinterface

// File: rtl/ternary_seq_ctrl.sv
// Phase sequencer for the ternary matmul engine: turns LOAD/RUN host commands into
// load-unit beats and multiplier row steps, with abort and hold (stall) control.
module ternary_seq_ctrl #(
  parameter int MAX_OUT_LEN = 7,
  parameter int LEN_W       = 8,
  parameter int RW          = $clog2(MAX_OUT_LEN)
) (
  input logic               clk,
  input logic               rst_n,
  ternary_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  localparam logic [1:0]    OP_LOAD  = 2'b01;
  localparam logic [1:0]    OP_RUN   = 2'b10;
  localparam logic [RW-1:0] LAST_ROW = RW'(MAX_OUT_LEN - 1);

  state_t           state_q, state_d;
  logic             half_q, half_d;
  logic [RW-1:0]    row_q, row_d;
  logic [LEN_W-1:0] vec_left_q, vec_left_d;
  logic             cont_q, cont_d;
  logic             wv_q, wv_d;
  logic             err_q, err_d;

  logic in_idle, in_load, in_ready, in_run;
  logic accept, load_go, mult_go, last_row;

  assign in_idle  = (state_q == S_IDLE);
  assign in_load  = (state_q == S_LOAD);
  assign in_ready = (state_q == S_READY);
  assign in_run   = (state_q == S_RUN);

  // abort masks cmd_ready, so it always wins over a same-cycle command
  assign bus.cmd_ready = (in_idle || in_ready) && !bus.abort;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign load_go       = in_load && !bus.hold;
  assign mult_go       = in_run && !bus.hold;
  assign last_row      = (row_q == LAST_ROW);

  assign bus.load_en       = load_go;
  assign bus.load_idx      = in_load ? {half_q, row_q} : '0;
  assign bus.mult_en       = mult_go;
  assign bus.mult_row      = in_run ? row_q : '0;
  assign bus.vec_done      = mult_go && last_row;
  assign bus.weights_valid = wv_q;
  assign bus.busy          = in_load || in_run;
  assign bus.err           = err_q;

  // row_q is shared: load beat row inside LOAD, matrix row inside RUN
  always_comb begin
    state_d    = state_q;
    half_d     = half_q;
    row_d      = row_q;
    vec_left_d = vec_left_q;
    cont_d     = cont_q;
    wv_d       = wv_q;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE, S_READY: begin
        if (accept) begin
          if (bus.cmd_op == OP_LOAD) begin
            state_d = S_LOAD;
            half_d  = 1'b0;
            row_d   = '0;
            wv_d    = 1'b0;
          end else if (bus.cmd_op == OP_RUN) begin
            if (in_ready) begin
              state_d    = S_RUN;
              row_d      = '0;
              vec_left_d = bus.cmd_len;
              cont_d     = (bus.cmd_len == '0);
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end

      S_LOAD: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          half_d  = 1'b0;
          row_d   = '0;
          wv_d    = 1'b0;
        end else if (load_go) begin
          if (last_row) begin
            row_d = '0;
            if (half_q) begin
              state_d = S_READY;
              half_d  = 1'b0;
              wv_d    = 1'b1;
            end else begin
              half_d = 1'b1;
            end
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end

      S_RUN: begin
        if (bus.abort) begin
          state_d = S_READY;
          row_d   = '0;
        end else if (mult_go) begin
          if (last_row) begin
            row_d = '0;
            if (!cont_q) begin
              vec_left_d = vec_left_q - 1'b1;
              if (vec_left_q == LEN_W'(1)) state_d = S_READY;
            end
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      half_q     <= 1'b0;
      row_q      <= '0;
      vec_left_q <= '0;
      cont_q     <= 1'b0;
      wv_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      row_q      <= row_d;
      vec_left_q <= vec_left_d;
      cont_q     <= cont_d;
      wv_q       <= wv_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_ternary_seq_ctrl.sv
// Scoreboard bench for ternary_seq_ctrl: directed protocol cases followed by random
// command/hold/abort traffic, checked against a transaction-level model.
module tb_ternary_seq_ctrl;

  localparam int M     = 7;
  localparam int LEN_W = 8;
  localparam int RW    = $clog2(M);
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  logic clk;
  logic rst_n;

  ternary_seq_ctrl_if #(.MAX_OUT_LEN(M), .LEN_W(LEN_W), .RW(RW)) bus ();

  ternary_seq_ctrl #(.MAX_OUT_LEN(M), .LEN_W(LEN_W), .RW(RW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // expected beat stream: load indices, and multiplier entries row*2+vec_done
  int load_q[$];
  int mult_q[$];
  bit m_wv;  // model: weights held; when not busy, idle <=> !m_wv

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input int b);
    return ((b / M) << RW) | (b % M);
  endfunction

  // monitor: consumes one expected beat per enable cycle
  always @(negedge clk) begin
    int e;
    if (bus.load_en) begin
      if (load_q.size() == 0) check("load_unexpected", 1, 0);
      else begin
        e = load_q.pop_front();
        check("load_idx", 32'(bus.load_idx), e);
      end
    end
    if (bus.mult_en) begin
      if (mult_q.size() == 0) check("mult_unexpected", 1, 0);
      else begin
        e = mult_q.pop_front();
        check("mult_row_done", 32'(bus.mult_row) * 2 + 32'(bus.vec_done), e);
      end
    end else begin
      check("vec_done_idle", 32'(bus.vec_done), 0);
    end
  end

  task automatic accept_cmd(input logic [1:0] op, input int len,
                            output int exp_beats, output bit err_case);
    int n;
    exp_beats = 0;
    err_case  = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_len   = LEN_W'(len);
    @(negedge clk);
    check("cmd_ready", 32'(bus.cmd_ready), 1);
    if (op == OP_LOAD) begin
      for (int b = 0; b < 2 * M; b++) load_q.push_back(idx_of(b));
      exp_beats = 2 * M;
      m_wv = 1'b0;
    end else if (op == OP_RUN) begin
      if (!m_wv) err_case = 1'b1;
      else begin
        n = (len == 0) ? 3 : len;  // continuous runs are always ended by abort
        for (int b = 0; b < n * M; b++)
          mult_q.push_back((b % M) * 2 + ((b % M == M - 1) ? 1 : 0));
        exp_beats = n * M;
      end
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
  endtask

  task automatic do_op(input logic [1:0] op, input int len, input int hold_pct,
                       input int hold_lo, input int hold_hi, input int abort_at);
    int exp_beats, beats, holds, cyc;
    bit err_case, aborted, got_end, was_load;
    accept_cmd(op, len, exp_beats, err_case);
    was_load = (op == OP_LOAD);
    if (err_case) begin
      @(negedge clk);
      check("err_pulse", 32'(bus.err), 1);
      check("err_busy", 32'(bus.busy), 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("err_clear", 32'(bus.err), 0);
      check("err_wv", 32'(bus.weights_valid), 0);
      @(posedge clk); #1;
      return;
    end
    if (exp_beats == 0) begin
      @(negedge clk);
      check("nop_busy", 32'(bus.busy), 0);
      check("nop_err", 32'(bus.err), 0);
      check("nop_wv", 32'(bus.weights_valid), 32'(m_wv));
      @(posedge clk); #1;
      return;
    end
    beats = 0; holds = 0; cyc = 0; aborted = 0; got_end = 0;
    while (cyc < 2000) begin
      bus.hold  = ((cyc >= hold_lo) && (cyc <= hold_hi)) || ($urandom_range(99) < hold_pct);
      bus.abort = (cyc == abort_at);
      @(negedge clk);
      if (!bus.busy) begin
        got_end = 1;
        break;
      end
      if (bus.hold) begin
        holds++;
        if (was_load) begin
          check("hold_load_en", 32'(bus.load_en), 0);
          check("hold_load_idx", 32'(bus.load_idx), idx_of(beats));
        end else begin
          check("hold_mult_en", 32'(bus.mult_en), 0);
          check("hold_mult_row", 32'(bus.mult_row), beats % M);
        end
      end else begin
        beats++;
      end
      @(posedge clk); #1;
      cyc++;
      if (bus.abort) begin
        aborted = 1;
        break;
      end
    end
    if (aborted) begin
      bus.abort = 1'b0;
      bus.hold  = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(bus.busy), 0);
      check("abort_load_en", 32'(bus.load_en), 0);
      check("abort_mult_en", 32'(bus.mult_en), 0);
      check("abort_wv", 32'(bus.weights_valid), was_load ? 0 : 1);
      check("abort_cmd_ready", 32'(bus.cmd_ready), 1);
      load_q.delete();
      mult_q.delete();
      m_wv = !was_load;
      @(posedge clk); #1;
    end else if (got_end) begin
      check("done_beats", beats, exp_beats);
      check("done_cycles", cyc, exp_beats + holds);
      check("done_queue_empty", load_q.size() + mult_q.size(), 0);
      check("done_wv", 32'(bus.weights_valid), 1);
      check("done_cmd_ready", 32'(bus.cmd_ready), 32'(!bus.abort));
      m_wv = 1'b1;
      bus.hold  = 1'b0;
      bus.abort = 1'b0;
      @(posedge clk); #1;
    end else begin
      check("op_timeout", 0, 1);
      bus.hold  = 1'b0;
      bus.abort = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load_en"}, 32'(bus.load_en), 0);
    check({tag, "_load_idx"}, 32'(bus.load_idx), 0);
    check({tag, "_mult_en"}, 32'(bus.mult_en), 0);
    check({tag, "_mult_row"}, 32'(bus.mult_row), 0);
    check({tag, "_vec_done"}, 32'(bus.vec_done), 0);
    check({tag, "_wv"}, 32'(bus.weights_valid), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_err"}, 32'(bus.err), 0);
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 1);
  endtask

  initial begin
    int eb;
    bit ec;
    int r, op_len, hp, ab;
    logic [1:0] op;

    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_len   = '0;
    bus.abort     = 1'b0;
    bus.hold      = 1'b0;
    m_wv = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // LOAD clean, LOAD with a 3-cycle hold at beat 3, then RUN of 3 vectors
    do_op(OP_LOAD, 0, 0, -1, -1, -1);
    do_op(OP_LOAD, 0, 0, 3, 5, -1);
    do_op(OP_RUN, 3, 0, -1, -1, -1);
    do_op(OP_NOP, 0, 0, -1, -1, -1);
    do_op(OP_RSV, 0, 0, -1, -1, -1);
    // continuous RUN aborted at row 4
    do_op(OP_RUN, 0, 0, -1, -1, 4);

    // abort in the same cycle as a LOAD command: command must not be taken
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_LOAD;
    bus.abort     = 1'b1;
    @(negedge clk);
    check("abort_cmd_ready_low", 32'(bus.cmd_ready), 0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.abort     = 1'b0;
    @(negedge clk);
    check("abort_cmd_busy", 32'(bus.busy), 0);
    check("abort_cmd_wv", 32'(bus.weights_valid), 1);
    @(posedge clk); #1;

    // LOAD aborted at beat 5, then RUN from IDLE must flag err
    do_op(OP_LOAD, 0, 0, -1, -1, 5);
    do_op(OP_RUN, 2, 0, -1, -1, -1);

    // asynchronous reset in the middle of a RUN
    do_op(OP_LOAD, 0, 0, -1, -1, -1);
    accept_cmd(OP_RUN, 2, eb, ec);
    check("rst_run_accepted", 32'(ec), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_pre_row", 32'(bus.mult_row), 2);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    load_q.delete();
    mult_q.delete();
    m_wv = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(OP_RUN, 1, 0, -1, -1, -1);

    // random traffic
    repeat (40) begin
      r = $urandom_range(9);
      op = (r < 4) ? OP_LOAD : (r < 8) ? OP_RUN : (r == 8) ? OP_NOP : OP_RSV;
      op_len = $urandom_range(1, 3);
      hp = $urandom_range(0, 40);
      ab = ($urandom_range(3) == 0) ? $urandom_range(0, 20) : -1;
      do_op(op, op_len, hp, -1, -1, ab);
    end

    repeat (2) @(posedge clk);
    check("final_queue_empty", load_q.size() + mult_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ternary_seq_ctrl.md
# ternary_seq_ctrl

Phase sequencer for the tiny ternary matmul engine. It accepts host commands to load a ternary weight matrix or to run N input vectors through the multiplier, and drives the load unit's enable and beat index and the multiplier's enable and row index. It replaces free-running phase and count logic with an explicit command, abort and stall protocol, and sits between the top-level pin decoder and the load and mult units.

## Interface
- MAX_OUT_LEN, default 7: output rows per vector; must be ≥2.
- LEN_W, default 8: width of the vector-count field.
- RW, default $clog2(MAX_OUT_LEN): row index width (3 at default).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_op  in  2  00 NOP, 01 LOAD, 10 RUN, 11 reserved (treated as NOP).
- cmd_len  in  LEN_W  RUN vector count; 0 means continuous.
- cmd_ready  out  1  command accepted on an edge where cmd_valid & cmd_ready.
- abort  in  1  level; stops LOAD or RUN.
- hold  in  1  level; freezes LOAD and RUN progress.
- load_en  out  1  load unit captures the input word this cycle.
- load_idx  out  RW+1  {half, row}: half 0/1, row 0..MAX_OUT_LEN-1.
- mult_en  out  1  multiplier active this cycle.
- mult_row  out  RW  row being computed.
- vec_done  out  1  last row of a vector this cycle.
- weights_valid  out  1  a complete weight set is held.
- busy  out  1  state is LOAD or RUN.
- err  out  1  one-cycle pulse: RUN accepted while weights invalid.

## Operation
States: IDLE, LOAD, READY, RUN. All state and counters are flops. Outputs are decoded from those flops only.

- cmd_ready = (IDLE | READY) & !abort.
- IDLE, accept LOAD: go to LOAD; beat counter = 0; weights_valid = 0.
- IDLE, accept RUN: stay in IDLE; err = 1 on the next cycle.
- IDLE, accept NOP or reserved: consumed, no effect.
- READY, accept LOAD: go to LOAD; weights_valid cleared at the accept edge.
- READY, accept RUN: go to RUN; row = 0; vec_left = cmd_len; continuous mode if cmd_len == 0.
- LOAD: 2·MAX_OUT_LEN beats.
  - load_idx steps {0,0}..{0,M-1}, {1,0}..{1,M-1}; at default that is 0..6, 8..14.
  - After the final beat: go to READY, weights_valid = 1.
- RUN: each non-held cycle, mult_row advances 0..M-1 and then wraps to 0.
  - At row M-1, vec_done = 1 and vec_left decrements unless in continuous mode.
  - At row M-1 with vec_left == 1: go to READY.
- hold high in LOAD or RUN:
  - load_en, mult_en and vec_done are 0.
  - Counters and state are frozen.
  - Ignored in IDLE and READY.
- abort:
  - In LOAD: go to IDLE, weights_valid stays 0.
  - In RUN: go to READY, weights_valid stays 1.
  - In IDLE or READY: no effect.
  - Beats the same-cycle cmd_valid, because cmd_ready is low.
  - Beats hold.
- load_en = LOAD & !hold. mult_en = RUN & !hold.
- load_idx and mult_row read 0 outside their own state.
- busy = LOAD | RUN.

## Timing
- Reset values:
  - State IDLE; all counters 0.
  - load_en, mult_en, vec_done, weights_valid, busy, err = 0.
  - load_idx = 0, mult_row = 0.
  - cmd_ready = 1 (decoded from IDLE).
- Reset mid-operation: immediate return to IDLE, weights_valid cleared, with no further enable pulses.
- Command accepted at edge k: the new state is visible from cycle k+1. The first load beat or mult row occurs in cycle k+1.
- LOAD with no hold takes exactly 2·M cycles, 14 at default. weights_valid rises in the cycle after the last beat; cmd_ready rises in that same cycle.
- RUN of N vectors with no hold takes exactly N·M cycles. vec_done occurs N times, in cycles k+M, k+2M, …
- A hold of H cycles extends LOAD or RUN by exactly H cycles.
- abort sampled at edge j: the state change is visible in cycle j+1 and no enable is asserted in cycle j+1.
- err is high exactly one cycle, cycle k+1.
- Back-to-back: a command can be accepted in the first READY cycle. RUN then follows LOAD with a 1-cycle gap.

## Test plan
- Reset, then LOAD with no hold: load_en is high for 14 cycles; load_idx sequence 0..6, 8..14; weights_valid = 1 in cycle 15; busy is low again in cycle 15.
- LOAD with hold high on beats 3–5: load_idx frozen at 3 during the hold, 17 total LOAD cycles, index sequence unchanged.
- RUN with cmd_len = 3 after LOAD: mult_row cycles 0..6 three times, vec_done in cycles 7, 14, 21, then READY with weights_valid still 1.
- RUN from IDLE: err pulses once, state stays IDLE, mult_en never asserts.
- abort in LOAD beat 5: IDLE next cycle, weights_valid = 0. abort in a continuous RUN at row 4: READY next cycle, weights_valid = 1. abort with cmd_valid LOAD in the same cycle: cmd_ready = 0 and the command is not taken.
- rst_n low during RUN row 2: asynchronously all outputs take their reset values and cmd_ready = 1. After release, a RUN command yields err = 1.
